// File: rtl/lane_highlighter_pkg.sv
// Shared globals for the lane-detection output stage: frame geometry, row band,
// highlight colour, lane fixed-point widths and the streaming state enum.
package lane_highlighter_pkg;

  localparam int WIDTH      = 1280;
  localparam int HEIGHT     = 720;
  localparam int IMAGE_SIZE = WIDTH * HEIGHT;
  localparam int STARTING_Y = 500;
  localparam int ENDING_Y   = 719;
  localparam int HALF_WIDTH = 2;
  localparam logic [23:0] HIGHLIGHT_COLOR = 24'hFF0000;

  // Lane x is Q12.8, slope is Q8.8; the slope is widened to the accumulator width
  localparam int ACC_W    = 20;
  localparam int SLOPE_W  = 16;
  localparam int FRAC_W   = 8;
  localparam int LANE_X_W = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Per-channel 50% mix; halving each channel first keeps every sum inside 8 bits
  function automatic logic [23:0] blend_half(input logic [23:0] pixel, input logic [23:0] color);
    return ((pixel >> 1) & 24'h7F7F7F) + ((color >> 1) & 24'h7F7F7F);
  endfunction

endpackage

// File: rtl/lane_highlighter_lane_tracker.sv
// One lane line: Q12.8 x accumulator stepped by the slope once per banded row,
// rounded to an integer column and tested against the current pixel.
module lane_tracker #(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int STARTING_Y = 500,
  parameter int ENDING_Y   = 719,
  parameter int HALF_WIDTH = 2
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     load,
  input  logic                                     step,
  input  logic [lane_highlighter_pkg::ACC_W-1:0]   x0,
  input  logic [lane_highlighter_pkg::SLOPE_W-1:0] slope,
  input  logic [X_W-1:0]                           x,
  input  logic [Y_W-1:0]                           y,
  output logic                                     match
);
  import lane_highlighter_pkg::*;

  localparam logic [Y_W-1:0]     FIRST_Y = Y_W'(STARTING_Y);
  localparam logic [Y_W-1:0]     LAST_Y  = Y_W'(ENDING_Y);
  localparam logic signed [15:0] HW_C    = 16'(HALF_WIDTH);

  logic [ACC_W-1:0]           acc;
  logic signed [LANE_X_W-1:0] lane_x;
  logic signed [15:0]         dx;
  logic                       in_band;

  // accumulator: loaded at frame start, wraps silently when stepped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= x0;
    end else if (step) begin
      acc <= acc + {{(ACC_W-SLOPE_W){slope[SLOPE_W-1]}}, slope};
    end else begin
      acc <= acc;
    end
  end

  // round half up on the first fraction bit, then distance test in the row band
  always_comb begin
    lane_x  = $signed({acc[ACC_W-1], acc[ACC_W-1:FRAC_W]})
            + $signed({{(LANE_X_W-1){1'b0}}, acc[FRAC_W-1]});
    dx      = $signed({{(16-X_W){1'b0}}, x})
            - $signed({{(16-LANE_X_W){lane_x[LANE_X_W-1]}}, lane_x});
    in_band = (y >= FIRST_Y) && (y <= LAST_Y);
    match   = in_band && (dx <= HW_C) && (dx >= -HW_C);
  end

endmodule

// File: rtl/lane_highlighter.sv
// Streams the frame out of the image BRAM in raster order and recolours lane pixels.
// Optional LANE_HIGHLIGHT_BLEND_EN: matched pixels are 50% blended instead of replaced.
module lane_highlighter #(
  parameter int          WIDTH           = lane_highlighter_pkg::WIDTH,
  parameter int          HEIGHT          = lane_highlighter_pkg::HEIGHT,
  parameter int          STARTING_Y      = lane_highlighter_pkg::STARTING_Y,
  parameter int          ENDING_Y        = lane_highlighter_pkg::ENDING_Y,
  parameter int          HALF_WIDTH      = lane_highlighter_pkg::HALF_WIDTH,
  parameter logic [23:0] HIGHLIGHT_COLOR = lane_highlighter_pkg::HIGHLIGHT_COLOR
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [lane_highlighter_pkg::ACC_W-1:0]   left_x0,
  input  logic [lane_highlighter_pkg::SLOPE_W-1:0] left_slope,
  input  logic [lane_highlighter_pkg::ACC_W-1:0]   right_x0,
  input  logic [lane_highlighter_pkg::SLOPE_W-1:0] right_slope,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]          bram_rd_addr,
  input  logic [23:0]                              bram_rd_data,
  output logic                                     out_wr_en,
  input  logic                                     out_full,
  output logic [23:0]                              out_din,
  output logic                                     busy,
  output logic                                     done
);
  import lane_highlighter_pkg::*;

  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);
  localparam int AW  = $clog2(WIDTH*HEIGHT);
  localparam logic [X_W-1:0] X_LAST  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(HEIGHT - 1);
  localparam logic [Y_W-1:0] FIRST_Y = Y_W'(STARTING_Y);
  localparam logic [AW-1:0]  W_C     = AW'(WIDTH);

  state_t         state;
  state_t         state_next;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           write, row_end, frame_end, load, step;
  logic           left_match, right_match;
  logic [AW-1:0]  cur_addr, next_addr;
  logic [23:0]    hit_pixel;

  assign write     = (state == STREAM) && !out_full;
  assign row_end   = write && (x == X_LAST);
  assign frame_end = row_end && (y == Y_LAST);
  assign load      = (state == IDLE) && start;
  assign step      = row_end && (y >= FIRST_Y);

  lane_tracker #(
    .X_W(X_W), .Y_W(Y_W), .STARTING_Y(STARTING_Y), .ENDING_Y(ENDING_Y), .HALF_WIDTH(HALF_WIDTH)
  ) u_left (
    .clock(clock), .reset(reset), .load(load), .step(step),
    .x0(left_x0), .slope(left_slope), .x(x), .y(y), .match(left_match)
  );

  lane_tracker #(
    .X_W(X_W), .Y_W(Y_W), .STARTING_Y(STARTING_Y), .ENDING_Y(ENDING_Y), .HALF_WIDTH(HALF_WIDTH)
  ) u_right (
    .clock(clock), .reset(reset), .load(load), .step(step),
    .x0(right_x0), .slope(right_slope), .x(x), .y(y), .match(right_match)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; start outside IDLE is ignored
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = STREAM; else state_next = IDLE;
      STREAM:  if (frame_end) state_next = DONE; else state_next = STREAM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // raster coordinates advance only on an accepted write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= '0;
      y <= '0;
    end else if (write) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end else begin
      x <= x;
      y <= y;
    end
  end

  // read address for the pixel after the current one; row wrap is just +1
  always_comb begin
    cur_addr = AW'(y) * W_C + AW'(x);
    if ((x == X_LAST) && (y == Y_LAST)) begin
      next_addr = '0;
    end else begin
      next_addr = cur_addr + AW'(1);
    end
  end

`ifdef LANE_HIGHLIGHT_BLEND_EN
  assign hit_pixel = blend_half(bram_rd_data, HIGHLIGHT_COLOR);
`else
  assign hit_pixel = HIGHLIGHT_COLOR;
`endif

  // outputs; a stalled cycle re-reads the current address so data stays valid
  always_comb begin
    out_wr_en    = 1'b0;
    out_din      = '0;
    busy         = 1'b0;
    done         = 1'b0;
    bram_rd_addr = '0;
    case (state)
      IDLE: bram_rd_addr = '0;
      STREAM: begin
        busy = 1'b1;
        if (out_full) begin
          bram_rd_addr = cur_addr;
        end else begin
          bram_rd_addr = next_addr;
          out_wr_en    = 1'b1;
          out_din      = (left_match || right_match) ? hit_pixel : bram_rd_data;
        end
      end
      DONE:    done = 1'b1;
      default: bram_rd_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_lane_highlighter.sv
// Scoreboard bench for lane_highlighter on a reduced 32x16 frame: expected pixels
// are queued at start and popped on every FIFO write.
module tb_lane_highlighter;
  localparam int W  = 32;
  localparam int H  = 16;
  localparam int SY = 4;
  localparam int EY = 12;
  localparam int HW = 2;
  localparam logic [23:0] HC = 24'hFF0000;
  localparam int AW = $clog2(W*H);
  localparam int BURST_AT = 8*W + 31;

  logic          clock = 1'b0;
  logic          reset, start, out_full;
  logic [19:0]   left_x0, right_x0;
  logic [15:0]   left_slope, right_slope;
  logic [AW-1:0] bram_rd_addr;
  logic [23:0]   bram_rd_data, out_din;
  logic          out_wr_en, busy, done;

  always #5 clock = ~clock;

  lane_highlighter #(
    .WIDTH(W), .HEIGHT(H), .STARTING_Y(SY), .ENDING_Y(EY), .HALF_WIDTH(HW), .HIGHLIGHT_COLOR(HC)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .left_x0(left_x0), .left_slope(left_slope), .right_x0(right_x0), .right_slope(right_slope),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .busy(busy), .done(done)
  );

  function automatic logic [23:0] pix(input int a);
    logic [31:0] t;
    t = a * 32'h0001_0203 + 32'h0012_3457;
    return t[23:0];
  endfunction

  always @(posedge clock) bram_rd_data <= pix(int'(bram_rd_addr));

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q[$];
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, writes = 0, stalls = 0;
  bit in_frame = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit on_lane(input int x, input int y, input int x0, input int s);
    int c;
    c = (x0 + s * (y - SY) + 128) >>> 8;
    return ((x - c) <= HW) && ((c - x) <= HW);
  endfunction

  function automatic logic [23:0] exp_pix(input int x, input int y, input int lx, input int ls,
                                          input int rx, input int rs);
    logic [23:0] p, c;
    p = pix(y * W + x);
    c = HC;
    if (y < SY || y > EY) return p;
    if (!on_lane(x, y, lx, ls) && !on_lane(x, y, rx, rs)) return p;
`ifdef LANE_HIGHLIGHT_BLEND_EN
    return {p[23:16] / 8'd2 + c[23:16] / 8'd2, p[15:8] / 8'd2 + c[15:8] / 8'd2,
            p[7:0] / 8'd2 + c[7:0] / 8'd2};
`else
    return c;
`endif
  endfunction

  // monitor on the falling edge
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (start) start_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (out_wr_en) begin
          writes++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_eq("pixel", {8'd0, out_din}, {8'd0, e});
          end
        end else begin
          if (in_frame) chk_eq("din_zero_when_idle", {8'd0, out_din}, 32'd0);
          if (in_frame && out_full && exp_q.size() > 0) stalls++;
        end
      end
    end
  end

  task automatic run_frame(input logic [19:0] lx0, input logic [15:0] ls, input logic [19:0] rx0,
                           input logic [15:0] rs, input bit bp, input int abort_at);
    int lxi, lsi, rxi, rsi, n, burst_left, wr_at_abort;
    bit toggle, burst_done;
    lxi = $signed(lx0); lsi = $signed(ls); rxi = $signed(rx0); rsi = $signed(rs);
    exp_q.delete();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back(exp_pix(xx, yy, lxi, lsi, rxi, rsi));
    writes = 0; stalls = 0; done_cnt = 0;
    @(posedge clock); #1;
    left_x0 = lx0; left_slope = ls; right_x0 = rx0; right_slope = rs;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    in_frame = 1'b1;
    chk_eq("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0; burst_left = 0; toggle = 1'b0; burst_done = 1'b0;
    while (done_cnt == 0 && n < 4*W*H + 100 && !(abort_at > 0 && writes >= abort_at)) begin
      if (bp) begin
        if (burst_left > 0) begin
          out_full = 1'b1;
          burst_left--;
        end else if (!burst_done && writes == BURST_AT) begin
          out_full = 1'b1;
          burst_left = 9;
          burst_done = 1'b1;
        end else begin
          toggle = ~toggle;
          out_full = toggle;
        end
      end
      @(posedge clock); #1;
      n++;
    end
    out_full = 1'b0;
    if (abort_at > 0) begin
      chk_eq("abort_reached", 32'(writes), 32'(abort_at));
      reset = 1'b1;
      in_frame = 1'b0;
      @(negedge clock);
      chk_eq("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
      chk_eq("rst_busy", {31'd0, busy}, 32'd0);
      chk_eq("rst_addr", 32'(bram_rd_addr), 32'd0);
      wr_at_abort = writes;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      chk_eq("no_done_after_rst", 32'(done_cnt), 32'd0);
      chk_eq("no_write_after_rst", 32'(writes), 32'(wr_at_abort));
    end else begin
      chk_eq("done_pulsed", 32'(done_cnt), 32'd1);
      repeat (3) @(posedge clock);
      #1;
      chk_eq("done_one_cycle", 32'(done_cnt), 32'd1);
      chk_eq("write_count", 32'(writes), 32'(W*H));
      chk_eq("queue_drained", 32'(exp_q.size()), 32'd0);
      chk_eq("done_latency", 32'(done_cyc - start_cyc), 32'(W*H + stalls + 1));
      chk_eq("busy_after_done", {31'd0, busy}, 32'd0);
      in_frame = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_full = 1'b0;
    left_x0 = '0; left_slope = '0; right_x0 = '0; right_slope = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_eq("reset_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk_eq("reset_din", {8'd0, out_din}, 32'd0);
    chk_eq("reset_addr", 32'(bram_rd_addr), 32'd0);
    chk_eq("reset_busy", {31'd0, busy}, 32'd0);
    chk_eq("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // vertical lanes at 10.0 and 22.0, no backpressure
    run_frame(20'd2560, 16'h0000, 20'd5632, 16'h0000, 1'b0, 0);
    // sloped left lane (-0.5/row), right lane on the last column, with backpressure
    run_frame(20'd2560, 16'hFF80, 20'd7936, 16'h0000, 1'b1, 0);
    // lanes entering from off-image, aborted by reset mid-frame
    run_frame(20'hFFB00, 16'h0100, 20'd10240, 16'hFF00, 1'b0, 100);
    // same lanes restarted from address 0
    run_frame(20'hFFB00, 16'h0100, 20'd10240, 16'hFF00, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
